// File: rtl/stage_sequencer_pkg.sv
// Shared types and constants for the stage sequencer.
// Stage codes drive the signal generation unit unchanged; STAGE_HALT is a
// code of its own that the signal generation unit decodes as "no control".
package stage_sequencer_pkg;

    localparam int unsigned STAGE_COUNT  = 3;
    localparam int unsigned OPCODE_COUNT = 5;
    localparam int unsigned GROUP_COUNT  = 3;
    localparam int unsigned RETIRE_W     = 16;
    localparam int unsigned WAIT_W       = 4;

    // Wait-counter value at which a stalled memory access is abandoned.
    localparam logic [WAIT_W-1:0] MEM_TIMEOUT = 4'd15;

    typedef enum logic [STAGE_COUNT-1:0] {
        STAGE_IF   = 3'd0,
        STAGE_ID   = 3'd1,
        STAGE_EX   = 3'd2,
        STAGE_MEM  = 3'd3,
        STAGE_WB   = 3'd4,
        STAGE_HALT = 3'd5
    } stage_t;

    typedef enum logic [OPCODE_COUNT-1:0] {
        TYPE_NOP  = 5'd0,
        TYPE_ADD  = 5'd1,
        TYPE_SUB  = 5'd2,
        TYPE_LDS  = 5'd3,
        TYPE_LD_Y = 5'd4,
        TYPE_STS  = 5'd5,
        TYPE_RJMP = 5'd6
    } opcode_t;

    typedef enum logic [GROUP_COUNT-1:0] {
        GROUP_ALU    = 3'd0,
        GROUP_MEM    = 3'd1,
        GROUP_BRANCH = 3'd2,
        GROUP_MISC   = 3'd3
    } group_t;

    // Opcodes that need a data-memory access stage.
    function automatic logic is_mem_op(input opcode_t op);
        return (op == TYPE_LDS) || (op == TYPE_LD_Y) || (op == TYPE_STS);
    endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the instruction front end and the stage
// sequencer.
//   opcode_type, opcode_group : decoded instruction in flight (valid from ID)
//   mem_ready                 : memory access completes this cycle
//   halt_req, resume          : stop after retire / restart from HALT
//   pipeline_stage            : current stage code
//   instr_done, retired_count : retire pulse and retire counter
//   halted, bus_error         : HALT indication, sticky memory timeout flag
interface stage_sequencer_if;
    import stage_sequencer_pkg::*;

    opcode_t               opcode_type;
    group_t                opcode_group;
    logic                  mem_ready;
    logic                  halt_req;
    logic                  resume;
    stage_t                pipeline_stage;
    logic                  instr_done;
    logic [RETIRE_W-1:0]   retired_count;
    logic                  halted;
    logic                  bus_error;

    modport master (
        output opcode_type, opcode_group, mem_ready, halt_req, resume,
        input  pipeline_stage, instr_done, retired_count, halted, bus_error
    );

    modport slave (
        input  opcode_type, opcode_group, mem_ready, halt_req, resume,
        output pipeline_stage, instr_done, retired_count, halted, bus_error
    );

endinterface

// File: rtl/stage_sequencer_mem_wait_timer.sv
// Memory wait timer: counts MEM cycles spent waiting on mem_ready.
//   clk, reset : clock, async active-high reset
//   clear      : restart from zero (MEM entry)
//   count_en   : a MEM cycle passed without mem_ready
//   expired    : counter has reached MEM_TIMEOUT
module mem_wait_timer
    import stage_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [WAIT_W-1:0] count_q;

    // Saturate at the timeout value; the sequencer leaves MEM at that point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en && (count_q != MEM_TIMEOUT)) begin
            count_q <= count_q + WAIT_W'(1);
        end
    end

    assign expired = (count_q == MEM_TIMEOUT);

endmodule

// File: rtl/stage_sequencer.sv
// Stage sequencer: steps an instruction through IF/ID/EX/[MEM]/WB, stops in
// HALT on request or on a memory timeout, and counts retired instructions.
//   clk, reset : clock, async active-high reset
//   bus        : stage_sequencer_if.slave (decoded opcode, mem_ready,
//                halt_req, resume in; stage and status out)
module stage_sequencer
    import stage_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    stage_sequencer_if.slave   bus
);

    stage_t              state_q;
    stage_t              state_d;
    logic                mem_entry;
    logic                count_en;
    logic                expired;
    logic                timeout;
    logic                resume_hit;
    logic                instr_done_q;
    logic                halted_q;
    logic                bus_error_q;
    logic [RETIRE_W-1:0] retired_q;

    // Opcode group is consumed downstream; stage sequencing needs only the type.
    logic unused_group;
    assign unused_group = ^bus.opcode_group;

    mem_wait_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (mem_entry),
        .count_en (count_en),
        .expired  (expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STAGE_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and timer/status strobes.
    always_comb begin
        state_d    = state_q;
        mem_entry  = 1'b0;
        count_en   = 1'b0;
        timeout    = 1'b0;
        resume_hit = 1'b0;
        case (state_q)
            STAGE_IF: state_d = STAGE_ID;
            STAGE_ID: state_d = STAGE_EX;
            STAGE_EX: begin
                if (is_mem_op(bus.opcode_type)) begin
                    state_d   = STAGE_MEM;
                    mem_entry = 1'b1;
                end else begin
                    state_d = STAGE_WB;
                end
            end
            STAGE_MEM: begin
                // A late acknowledge in the timeout cycle still completes.
                if (bus.mem_ready) begin
                    state_d = STAGE_WB;
                end else if (expired) begin
                    state_d = STAGE_HALT;
                    timeout = 1'b1;
                end else begin
                    count_en = 1'b1;
                end
            end
            STAGE_WB: begin
                state_d = bus.halt_req ? STAGE_HALT : STAGE_IF;
            end
            STAGE_HALT: begin
                if (bus.resume) begin
                    state_d    = STAGE_IF;
                    resume_hit = 1'b1;
                end
            end
            default: state_d = STAGE_IF;
        endcase
    end

    // Status registers, loaded from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_done_q <= 1'b0;
            halted_q     <= 1'b0;
            retired_q    <= '0;
            bus_error_q  <= 1'b0;
        end else begin
            instr_done_q <= (state_d == STAGE_WB);
            halted_q     <= (state_d == STAGE_HALT);
            if (state_d == STAGE_WB) begin
                retired_q <= retired_q + RETIRE_W'(1);
            end
            if (timeout) begin
                bus_error_q <= 1'b1;
            end else if (resume_hit) begin
                bus_error_q <= 1'b0;
            end
        end
    end

    assign bus.pipeline_stage = state_q;
    assign bus.instr_done     = instr_done_q;
    assign bus.halted         = halted_q;
    assign bus.retired_count  = retired_q;
    assign bus.bus_error      = bus_error_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: per-cycle expectations are queued
// while each instruction is planned, then popped and compared cycle by cycle.
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    typedef struct {
        opcode_t     op;
        group_t      grp;
        logic        mem_ready;
        logic        halt_req;
        logic        resume;
        stage_t      stage;
        logic        done;
        logic [15:0] count;
        logic        halted;
        logic        berr;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    stage_sequencer_if bus ();

    stage_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    vec_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_count = 16'd0;
    logic        exp_berr  = 1'b0;
    opcode_t     cur_op    = TYPE_NOP;
    group_t      cur_grp   = GROUP_ALU;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input stage_t st, input logic mr, input logic hr, input logic rs);
        vec_t v;
        v.op        = cur_op;
        v.grp       = cur_grp;
        v.mem_ready = mr;
        v.halt_req  = hr;
        v.resume    = rs;
        v.stage     = st;
        v.done      = (st == STAGE_WB);
        v.count     = exp_count;
        v.halted    = (st == STAGE_HALT);
        v.berr      = exp_berr;
        sb.push_back(v);
    endtask

    // waits < 0 means mem_ready never arrives (timeout into HALT).
    task automatic plan_instr(input opcode_t op, input group_t grp, input bit mem,
                              input int waits, input bit noise,
                              input bit halt_wb, input bit resume_wb);
        cur_op  = op;
        cur_grp = grp;
        push(STAGE_IF, noise, noise, noise);
        push(STAGE_ID, noise, noise, noise);
        push(STAGE_EX, noise, noise, noise);
        if (mem) begin
            if (waits < 0) begin
                for (int i = 0; i < 16; i++) push(STAGE_MEM, 1'b0, noise, noise);
                exp_berr = 1'b1;
                return;
            end
            for (int i = 0; i < waits; i++) push(STAGE_MEM, 1'b0, noise, noise);
            push(STAGE_MEM, 1'b1, noise, noise);
        end
        exp_count = exp_count + 16'd1;
        push(STAGE_WB, noise, halt_wb, resume_wb);
    endtask

    // n HALT cycles, resume raised in the last one.
    task automatic plan_halt(input int n);
        for (int i = 0; i < n; i++) push(STAGE_HALT, 1'b1, 1'b0, (i == n - 1));
        exp_berr = 1'b0;
    endtask

    task automatic check_outputs(input vec_t v);
        check("stage",   32'(bus.pipeline_stage), 32'(v.stage));
        check("done",    32'(bus.instr_done),     32'(v.done));
        check("retired", 32'(bus.retired_count),  32'(v.count));
        check("halted",  32'(bus.halted),         32'(v.halted));
        check("bus_err", 32'(bus.bus_error),      32'(v.berr));
    endtask

    task automatic run_plan();
        vec_t v;
        while (sb.size() > 0) begin
            v = sb.pop_front();
            @(negedge clk);
            check_outputs(v);
            bus.opcode_type  = v.op;
            bus.opcode_group = v.grp;
            bus.mem_ready    = v.mem_ready;
            bus.halt_req     = v.halt_req;
            bus.resume       = v.resume;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stage"},   32'(bus.pipeline_stage), 32'(STAGE_IF));
        check({tag, "_done"},    32'(bus.instr_done),     32'd0);
        check({tag, "_retired"}, 32'(bus.retired_count),  32'd0);
        check({tag, "_halted"},  32'(bus.halted),         32'd0);
        check({tag, "_bus_err"}, 32'(bus.bus_error),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode_type  = TYPE_NOP;
        bus.opcode_group = GROUP_ALU;
        bus.mem_ready    = 1'b0;
        bus.halt_req     = 1'b0;
        bus.resume       = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #2 reset = 1'b0;

        // ALU op, no halt: IF,ID,EX,WB then IF.
        plan_instr(TYPE_ADD, GROUP_ALU, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        // LDS, three wait cycles; stray halt_req/resume/mem_ready before WB ignored.
        plan_instr(TYPE_LDS, GROUP_MEM, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        // Branch with noise: halt_req dropped before WB has no effect.
        plan_instr(TYPE_RJMP, GROUP_BRANCH, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        // STS never acknowledged: timeout into HALT, resume after 3 cycles.
        plan_instr(TYPE_STS, GROUP_MEM, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        plan_halt(3);
        // halt_req and resume together in WB: HALT first, resume next cycle.
        plan_instr(TYPE_SUB, GROUP_ALU, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        plan_halt(1);
        // LD_Y acknowledged in its first MEM cycle.
        plan_instr(TYPE_LD_Y, GROUP_MEM, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        // Acknowledge exactly in the timeout cycle completes normally.
        plan_instr(TYPE_LDS, GROUP_MEM, 1'b1, 15, 1'b0, 1'b0, 1'b0);
        // Plain halt request in WB, held in HALT for 4 cycles.
        plan_instr(TYPE_NOP, GROUP_MISC, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        plan_halt(4);
        run_plan();

        // Counter wrap: preload the counter as if 65535 retires had happened.
        force dut.retired_q = 16'hFFFF;
        #1 release dut.retired_q;
        exp_count = 16'hFFFF;
        plan_instr(TYPE_ADD, GROUP_ALU, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        plan_instr(TYPE_ADD, GROUP_ALU, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_plan();

        // LD_Y aborted by reset in its second MEM cycle.
        cur_op  = TYPE_LD_Y;
        cur_grp = GROUP_MEM;
        push(STAGE_IF, 1'b0, 1'b0, 1'b0);
        push(STAGE_ID, 1'b0, 1'b0, 1'b0);
        push(STAGE_EX, 1'b0, 1'b0, 1'b0);
        push(STAGE_MEM, 1'b0, 1'b0, 1'b0);
        run_plan();
        @(negedge clk);
        check("mem2_stage", 32'(bus.pipeline_stage), 32'(STAGE_MEM));
        #2 reset = 1'b1;
        #1 check_reset_values("async_reset");
        exp_count = 16'd0;
        exp_berr  = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        plan_instr(TYPE_ADD, GROUP_ALU, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        push(STAGE_IF, 1'b0, 1'b0, 1'b0);
        run_plan();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
